// File: rtl/uart_rx_pkg.sv
// Shared state encoding and bit-timing constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_WIDTH_DEF = 8;

  // Strobe and result edges sit just past mid-bit: P/2 + offset.
  localparam int STRB_OFS = 2;
  localparam int RSLT_OFS = 3;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter: counts 0..edge_max,
// bumps the bit counter on each wrap, synchronous clear has priority.
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] edge_max,
  output logic                  wrap,
  output logic [PRESCALE_W-1:0] edge_nxt,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;

  assign wrap = en && (edge_cnt_q == edge_max);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en) begin
      if (wrap) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments and reset asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_nxt = edge_cnt_d;
  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP on oversampled
// edges, strobes the datapath blocks and qualifies each frame with data_valid.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stop_error,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  dat_samp_en_q, dat_samp_en_d;
  logic                  deser_en_q, deser_en_d;
  logic                  strt_chk_en_q, strt_chk_en_d;
  logic                  par_chk_en_q, par_chk_en_d;
  logic                  stp_chk_en_q, stp_chk_en_d;
  logic                  data_valid_q, data_valid_d;

  logic                  cnt_en, cnt_clr, wrap, at_r, at_s_nxt;
  logic [PRESCALE_W-1:0] edge_nxt, s_edge, r_edge;

  assign s_edge   = (p_q >> 1) + PRESCALE_W'(STRB_OFS);
  assign r_edge   = (p_q >> 1) + PRESCALE_W'(RSLT_OFS);
  assign at_r     = (edge_cnt == r_edge);
  assign at_s_nxt = (edge_nxt == s_edge);
  assign cnt_en   = (state_q != IDLE);
  assign cnt_clr  = (state_d == IDLE);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .edge_max (p_q - PRESCALE_W'(1)),
    .wrap     (wrap),
    .edge_nxt (edge_nxt),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  always_comb begin
    state_d      = state_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in) state_d = START;
      end
      START: begin
        if (at_r && strt_glitch) state_d = IDLE;
        else if (wrap)           state_d = DATA;
      end
      DATA: begin
        if (wrap && (bit_cnt == LAST_DATA_BIT)) state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (at_r && par_err) state_d = IDLE;
        else if (wrap)       state_d = STOP;
      end
      STOP: begin
        // The wrap exit only matters for illegal prescales whose R edge is never reached.
        if (at_r) begin
          state_d      = IDLE;
          data_valid_d = !stop_error;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes look at the next state/edge so the registered pulse lands on edge S.
  always_comb begin
    p_d = p_q;
    if ((state_q == IDLE) && (state_d == START)) p_d = prescale;
    dat_samp_en_d = (state_d != IDLE);
    strt_chk_en_d = (state_d == START)  && at_s_nxt;
    deser_en_d    = (state_d == DATA)   && at_s_nxt;
    par_chk_en_d  = (state_d == PARITY) && at_s_nxt;
    stp_chk_en_d  = (state_d == STOP)   && at_s_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      p_q           <= '0;
      dat_samp_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      strt_chk_en_q <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      dat_samp_en_q <= dat_samp_en_d;
      deser_en_q    <= deser_en_d;
      strt_chk_en_q <= strt_chk_en_d;
      par_chk_en_q  <= par_chk_en_d;
      stp_chk_en_q  <= stp_chk_en_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign dat_samp_en = dat_samp_en_q;
  assign deser_en    = deser_en_q;
  assign strt_chk_en = strt_chk_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stp_chk_en  = stp_chk_en_q;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table plus random
// frames, each cycle compared against a frame-timing model built from P, S and R.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en, strt_glitch, par_err, stop_error;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stop_error  (stop_error),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  typedef struct packed {
    logic [PW-1:0] edge_c;
    logic [3:0]    bit_c;
    logic          samp, deser, strt, par, stp, dv;
  } outs_t;

  typedef struct {
    int         p;
    logic       pe;
    logic [7:0] data;
    logic       glitch, perr, serr;
    int         gap;
    int         exp_end, exp_deser, exp_strt, exp_par, exp_stp, exp_dv;
  } frame_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.edge_c = edge_cnt;
    o.bit_c  = bit_cnt;
    o.samp   = dat_samp_en;
    o.deser  = deser_en;
    o.strt   = strt_chk_en;
    o.par    = par_chk_en;
    o.stp    = stp_chk_en;
    o.dv     = data_valid;
    return o;
  endfunction

  // Last non-idle cycle of a frame, counted from the first START cycle.
  function automatic int exit_cycle(frame_t f);
    int r = f.p / 2 + 3;
    if (f.glitch) return r;
    if (f.pe && f.perr) return (DW + 1) * f.p + r;
    return (DW + 1 + int'(f.pe)) * f.p + r;
  endfunction

  function automatic outs_t model_out(frame_t f, int t);
    outs_t o;
    int s    = f.p / 2 + 2;
    int bitn = t / f.p;
    int e    = t % f.p;
    o        = '0;
    o.edge_c = PW'(e);
    o.bit_c  = 4'(bitn);
    o.samp   = 1'b1;
    o.strt   = (bitn == 0) && (e == s);
    o.deser  = (bitn >= 1) && (bitn <= DW) && (e == s);
    o.par    = f.pe && (bitn == DW + 1) && (e == s);
    o.stp    = (bitn == DW + 1 + int'(f.pe)) && (e == s);
    return o;
  endfunction

  // Serial line level c cycles after the falling start edge.
  function automatic logic line_bit(frame_t f, int c);
    int k = c / f.p;
    if (f.glitch) return (c < 3) ? 1'b0 : 1'b1;
    if (k == 0) return 1'b0;
    if (k <= DW) return f.data[k-1];
    if (f.pe && (k == DW + 1)) return ^f.data;
    return 1'b1;
  endfunction

  task automatic drive(input logic rx, input logic [PW-1:0] p, input logic pe,
                       input logic g, input logic pr, input logic se);
    rx_in = rx; prescale = p; par_en = pe;
    strt_glitch = g; par_err = pr; stop_error = se;
  endtask

  // Checker flags are random until their result edge, then hold the frame's verdict.
  task automatic drive_frame_cycle(input frame_t f, input int t);
    int   r      = f.p / 2 + 3;
    int   par_r  = (DW + 1) * f.p + r;
    int   stop_r = (DW + 1 + int'(f.pe)) * f.p + r;
    logic g, pr, se, pe;
    g  = (t < r) ? 1'($urandom) : f.glitch;
    pr = (f.pe && t >= par_r) ? f.perr : 1'($urandom);
    se = (t < stop_r) ? 1'($urandom) : f.serr;
    pe = (t == (DW + 1) * f.p - 1) ? f.pe : 1'($urandom);
    drive(line_bit(f, t + 1), PW'($urandom), pe, g, pr, se);
  endtask

  task automatic idle_cycle(input logic rx, input logic [PW-1:0] p, input logic exp_dv,
                            input string name, output outs_t o);
    outs_t e;
    drive(rx, p, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    o    = sample();
    e    = '0;
    e.dv = exp_dv;
    check(name, o, e);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input frame_t f, input int idx, input bit started, input int next_p,
                           output int n_deser, output int n_strt, output int n_par,
                           output int n_stp, output int n_dv, output int end_obs);
    int    ex = exit_cycle(f);
    outs_t o;
    logic  ok = !f.glitch && !(f.pe && f.perr) && !f.serr;
    n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; end_obs = -1;
    if (!started) idle_cycle(1'b0, PW'(f.p), 1'b0, $sformatf("frame%0d start idle", idx), o);
    for (int t = 0; t <= ex; t++) begin
      drive_frame_cycle(f, t);
      @(negedge clk);
      o = sample();
      check($sformatf("frame%0d t=%0d outputs", idx, t), o, model_out(f, t));
      n_deser += int'(o.deser); n_strt += int'(o.strt); n_par += int'(o.par);
      n_stp += int'(o.stp); n_dv += int'(o.dv);
      if (!o.samp && end_obs < 0) end_obs = t;
      @(posedge clk); #1;
    end
    idle_cycle((f.gap == 0) ? 1'b0 : 1'b1, (f.gap == 0) ? PW'(next_p) : PW'($urandom), ok,
               $sformatf("frame%0d end idle", idx), o);
    n_dv += int'(o.dv);
    if (!o.samp && end_obs < 0) end_obs = ex + 1;
    for (int g = 1; g < f.gap; g++)
      idle_cycle(1'b1, PW'($urandom), 1'b0, $sformatf("frame%0d gap", idx), o);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    frame_t dir_tab[7];
    frame_t rnd_tab[20];
    frame_t rf;
    outs_t  o;
    int     nd, ns, np, nt, nv, eo, started;
    logic   seen, done;
    int     ill_p[3];

    dir_tab[0] = '{p:8,  pe:1'b0, data:8'hA5, glitch:1'b0, perr:1'b0, serr:1'b0, gap:3,
                   exp_end:80,  exp_deser:8, exp_strt:1, exp_par:0, exp_stp:1, exp_dv:1};
    dir_tab[1] = '{p:16, pe:1'b1, data:8'h5A, glitch:1'b0, perr:1'b1, serr:1'b0, gap:2,
                   exp_end:156, exp_deser:8, exp_strt:1, exp_par:1, exp_stp:0, exp_dv:0};
    dir_tab[2] = '{p:8,  pe:1'b0, data:8'h00, glitch:1'b1, perr:1'b0, serr:1'b0, gap:2,
                   exp_end:8,   exp_deser:0, exp_strt:1, exp_par:0, exp_stp:0, exp_dv:0};
    dir_tab[3] = '{p:32, pe:1'b0, data:8'h0F, glitch:1'b0, perr:1'b0, serr:1'b1, gap:1,
                   exp_end:308, exp_deser:8, exp_strt:1, exp_par:0, exp_stp:1, exp_dv:0};
    dir_tab[4] = '{p:8,  pe:1'b0, data:8'h3C, glitch:1'b0, perr:1'b0, serr:1'b0, gap:0,
                   exp_end:80,  exp_deser:8, exp_strt:1, exp_par:0, exp_stp:1, exp_dv:1};
    dir_tab[5] = '{p:8,  pe:1'b1, data:8'hC3, glitch:1'b0, perr:1'b0, serr:1'b0, gap:2,
                   exp_end:88,  exp_deser:8, exp_strt:1, exp_par:1, exp_stp:1, exp_dv:1};
    dir_tab[6] = '{p:16, pe:1'b1, data:8'h81, glitch:1'b0, perr:1'b0, serr:1'b0, gap:4,
                   exp_end:172, exp_deser:8, exp_strt:1, exp_par:1, exp_stp:1, exp_dv:1};

    rst = 1'b0;
    drive(1'b1, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset state", sample(), '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle(1'b1, PW'(8), 1'b0, "idle after reset", o);

    // Directed frames from the table.
    started = 0;
    for (int i = 0; i < 7; i++) begin
      run_frame(dir_tab[i], i, started != 0, (i < 6) ? dir_tab[i+1].p : 8, nd, ns, np, nt, nv, eo);
      check($sformatf("dir%0d end cycle", i),     eo, dir_tab[i].exp_end);
      check($sformatf("dir%0d deser_en count", i), nd, dir_tab[i].exp_deser);
      check($sformatf("dir%0d strt_chk count", i), ns, dir_tab[i].exp_strt);
      check($sformatf("dir%0d par_chk count", i),  np, dir_tab[i].exp_par);
      check($sformatf("dir%0d stp_chk count", i),  nt, dir_tab[i].exp_stp);
      check($sformatf("dir%0d data_valid count", i), nv, dir_tab[i].exp_dv);
      started = (dir_tab[i].gap == 0) ? 1 : 0;
    end

    // Asynchronous reset in the middle of data bit 4.
    rf = '{p:8, pe:1'b0, data:8'h96, glitch:1'b0, perr:1'b0, serr:1'b0, gap:2,
           exp_end:0, exp_deser:0, exp_strt:0, exp_par:0, exp_stp:0, exp_dv:0};
    idle_cycle(1'b0, PW'(8), 1'b0, "reset seq start idle", o);
    for (int t = 0; t < 35; t++) begin
      drive_frame_cycle(rf, t);
      @(posedge clk); #1;
    end
    drive_frame_cycle(rf, 35);
    @(negedge clk);
    check("pre-reset bit_cnt", bit_cnt, 4);
    #2 rst = 1'b0;
    #1 check("async reset mid-frame", sample(), '0);
    @(posedge clk); #1;
    check("reset held", sample(), '0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) idle_cycle(1'b1, PW'(8), 1'b0, "idle after mid-frame reset", o);
    run_frame(rf, 100, 1'b0, 8, nd, ns, np, nt, nv, eo);

    // Illegal prescale values must still bring the FSM back to IDLE.
    ill_p[0] = 3; ill_p[1] = 6; ill_p[2] = 0;
    for (int i = 0; i < 3; i++) begin
      idle_cycle(1'b0, PW'(ill_p[i]), 1'b0, "illegal P start idle", o);
      seen = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
        drive(1'b1, PW'(ill_p[i]), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        if (dat_samp_en) seen = 1'b1;
        else if (seen)   done = 1'b1;
        @(posedge clk); #1;
      end
      check($sformatf("illegal P=%0d returns to idle", ill_p[i]), {seen, done}, 2'b11);
      idle_cycle(1'b1, PW'(8), 1'b0, "idle after illegal P", o);
    end

    // Random frames, including back-to-back ones.
    foreach (rnd_tab[i]) begin
      case ($urandom_range(0, 3))
        0, 1:    rnd_tab[i].p = 8;
        2:       rnd_tab[i].p = 16;
        default: rnd_tab[i].p = 32;
      endcase
      rnd_tab[i].pe     = 1'($urandom);
      rnd_tab[i].data   = 8'($urandom);
      rnd_tab[i].glitch = ($urandom_range(0, 5) == 0);
      rnd_tab[i].perr   = ($urandom_range(0, 4) == 0);
      rnd_tab[i].serr   = ($urandom_range(0, 4) == 0);
      rnd_tab[i].gap    = (i == 19) ? 2 : int'($urandom_range(0, 3));
    end
    started = 0;
    for (int i = 0; i < 20; i++) begin
      run_frame(rnd_tab[i], 200 + i, started != 0, (i < 19) ? rnd_tab[i+1].p : 8,
                nd, ns, np, nt, nv, eo);
      started = (rnd_tab[i].gap == 0) ? 1 : 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. Tracks oversampling edges and bit position. Drives one-cycle enables to the data sampler, deserializer, start-glitch checker, parity checker and stop-bit checker, then reads their registered error flags. Emits a single `data_valid` pulse for each accepted frame, and sits between the serial input synchroniser and the RX datapath.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_W`, 6: width of the prescale and edge-counter buses.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx_in`  in  1  synchronised serial line, idle high.
- `prescale`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- `par_en`  in  1  a parity bit follows the data bits.
- `strt_glitch`  in  1  registered start-check result; 1 means false start.
- `par_err`  in  1  registered parity-check result.
- `stop_error`  in  1  registered stop-check result.
- `edge_cnt`  out  PRESCALE_W  oversampling edge index within the current bit.
- `bit_cnt`  out  4  bit index within the frame.
- `dat_samp_en`  out  1  sampler enable.
- `deser_en`  out  1  deserializer shift strobe.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each  checker strobes.
- `data_valid`  out  1  one-cycle frame-accepted pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Constants used below:
  - P = prescale latched on IDLE→START, held for the whole frame.
  - S = P/2+2 is the strobe edge.
  - R = P/2+3 is the result edge.
- IDLE:
  - edge_cnt=0, bit_cnt=0, all enables 0.
  - rx_in==0 moves to START next cycle.
- edge_cnt counts 0..P-1 in every non-IDLE state. It wraps to 0 at P-1, and bit_cnt increments on the wrap.
- dat_samp_en is 1 throughout START, DATA, PARITY and STOP.
- START:
  - strt_chk_en pulses at edge S.
  - At edge R, strt_glitch==1 sends the FSM to IDLE.
  - Otherwise the wrap at P-1 enters DATA with bit_cnt=1.
- DATA:
  - deser_en pulses at edge S of each data bit.
  - The wrap at P-1 with bit_cnt==DATA_WIDTH enters PARITY if par_en, else STOP.
- PARITY:
  - bit_cnt=DATA_WIDTH+1.
  - par_chk_en pulses at edge S.
  - At edge R, par_err sends the FSM to IDLE and the frame is dropped.
  - Otherwise the wrap enters STOP.
- STOP:
  - stp_chk_en pulses at edge S.
  - At edge R: stop_error==0 asserts data_valid for one cycle and goes to IDLE; stop_error==1 goes to IDLE with no data_valid.
  - STOP exits early, without waiting for the end of the stop bit. The line is still high at that point, so back-to-back frames and slow transmitters are tolerated.
- par_en is sampled on the DATA→PARITY/STOP decision only.
- Errors are not latched. A dropped frame leaves no trace beyond the absence of data_valid.

## Timing
- Reset (rst low, asynchronous): state=IDLE, edge_cnt=0, bit_cnt=0, all enables 0, data_valid=0.
- Reset mid-frame aborts the frame immediately, with no data_valid.
- All outputs are registered.
- Each strobe is exactly one clk wide, at edge_cnt==S in its state.
- Checker results are consumed exactly one cycle later, at edge R. The checkers register their flags one cycle after the strobe.
- data_valid is high in the cycle after the edge-R evaluation of STOP. The FSM is in IDLE that same cycle.
- An IDLE start detection in that cycle is allowed: it is the next frame.
- Frame latency, from the first START cycle to data_valid: P·(1+DATA_WIDTH+par_en) + R + 1 clk.
- Example: P=8, DATA_WIDTH=8, no parity gives 8·9+7+1 = 80 cycles.
- Changes on prescale mid-frame have no effect until the next IDLE→START.
- Illegal prescale values give undefined frame timing, but the FSM must still return to IDLE.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the state enum, with encoding IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - the DATA_WIDTH default;
  - the S/R offset constants (+2/+3), which are shared with the sampler and checkers.
- One sub-module, `uart_rx_edge_bit_cnt`:
  - edge and bit counters, with enable, wrap at P-1 and synchronous clear.
  - The FSM instantiates it and drives its enable and clear.

## Test plan
- P=8, no parity, frame 0xA5 with a good stop bit:
  - deser_en pulses 8 times at edge 6 of bits 1–8.
  - stp_chk_en pulses once at edge 6 of the stop bit.
  - data_valid is high for 1 cycle, 80 cycles after START entry.
- P=16, par_en=1, par_err forced 1 at edge 11 of the parity bit: FSM returns to IDLE, and no stp_chk_en or data_valid occurs.
- Start glitch: rx_in low for 3 cycles with strt_glitch=1 at edge R: FSM returns to IDLE with bit_cnt=0, and no deser_en occurs.
- P=32, stop_error=1 at edge 19 of the stop bit: no data_valid, and the FSM is in IDLE the next cycle.
- Back-to-back frames with P=8, start bit immediately following the stop bit: two data_valid pulses, and the second frame's START is entered without loss.
- Reset asserted during DATA at bit_cnt=4: all outputs are 0 asynchronously, and after release the FSM is in IDLE until rx_in falls.
